// File: rtl/hc_sr04_pkg.sv
// Shared FSM state type and cycle-count helpers for the HC-SR04 ranging controller.
package hc_sr04_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_ECHO,
    ST_MEASURE,
    ST_HOLD
  } state_e;

  // Clocks per microsecond
  function automatic int unsigned us_cycles(input int unsigned clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  // Clocks per millimetre of range (5.8 us round trip), truncated
  function automatic int unsigned mm_cycles(input int unsigned clk_hz);
    longint unsigned prod;
    prod = 64'(clk_hz) * 64'(58);
    return 32'(prod / 64'(10_000_000));
  endfunction

  function automatic int unsigned trig_cycles(input int unsigned clk_hz, input int unsigned trig_us);
    return us_cycles(clk_hz) * trig_us;
  endfunction

  function automatic int unsigned cycle_cycles(input int unsigned clk_hz, input int unsigned cycle_ms);
    return us_cycles(clk_hz) * cycle_ms * 1000;
  endfunction

  function automatic int unsigned timeout_cycles(input int unsigned clk_hz, input int unsigned time_us);
    return us_cycles(clk_hz) * time_us;
  endfunction

  localparam int unsigned DEF_CLK_HZ      = 100_000_000;
  localparam int unsigned DEF_TRIG_US     = 10;
  localparam int unsigned DEF_CYCLE_MS    = 60;
  localparam int unsigned DEF_TIMEOUT_US  = 30_000;
  localparam int unsigned DEF_ECHO_MAX_US = 38_000;

  // Derived constants at the default clock
  localparam int unsigned TRIG_CYCLES     = trig_cycles(DEF_CLK_HZ, DEF_TRIG_US);
  localparam int unsigned MM_CYCLES       = mm_cycles(DEF_CLK_HZ);
  localparam int unsigned CYCLE_CYCLES    = cycle_cycles(DEF_CLK_HZ, DEF_CYCLE_MS);
  localparam int unsigned TIMEOUT_CYCLES  = timeout_cycles(DEF_CLK_HZ, DEF_TIMEOUT_US);
  localparam int unsigned ECHO_MAX_CYCLES = timeout_cycles(DEF_CLK_HZ, DEF_ECHO_MAX_US);

endpackage

// File: rtl/hc_sr04_sync.sv
// Two-flop synchronizer for the echo input with rise/fall detection on the synchronized copy.
module hc_sr04_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_c,
  output logic fall_c
);

  logic meta;
  logic sync;
  logic sync_d;

  // Synchronizer chain plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise_c = sync & ~sync_d;
  assign fall_c = ~sync & sync_d;

endmodule

// File: rtl/hc_sr04_controller.sv
// HC-SR04 ultrasonic ranger: periodic trigger, echo width to millimetres, with timeouts.
module hc_sr04_controller
  import hc_sr04_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned CYCLE_MS    = 60,
  parameter int unsigned MAX_DIST    = 11600,
  parameter int unsigned TIMEOUT_US  = 30_000,
  parameter int unsigned ECHO_MAX_US = 38_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        echo,
  output logic                        trigger,
  output logic [$clog2(MAX_DIST)-1:0] distance
);

  localparam int unsigned US_LEN   = us_cycles(CLK_HZ);
  localparam int unsigned PER_US   = CYCLE_MS * 1000;
  localparam int unsigned MM_LEN   = mm_cycles(CLK_HZ);
  localparam int unsigned WAIT_LEN = timeout_cycles(CLK_HZ, TIMEOUT_US);
  localparam int unsigned MEAS_LEN = timeout_cycles(CLK_HZ, ECHO_MAX_US);
  localparam int unsigned TMR_LEN  = (MEAS_LEN > WAIT_LEN) ? MEAS_LEN : WAIT_LEN;

  localparam int unsigned DIST_W = $clog2(MAX_DIST);
  localparam int unsigned US_W   = $clog2(US_LEN + 1);
  localparam int unsigned PER_W  = $clog2(PER_US + 1);
  localparam int unsigned MM_W   = $clog2(MM_LEN + 1);
  localparam int unsigned TMR_W  = $clog2(TMR_LEN + 1);

  state_e state;
  state_e state_nxt;

  logic              echo_rise;
  logic              echo_fall;
  logic [US_W-1:0]   us_cnt;
  logic              us_tick;
  logic [PER_W-1:0]  per_cnt;
  logic [TMR_W-1:0]  tmr;
  logic [MM_W-1:0]   mm_pre;
  logic              mm_tick;
  logic [DIST_W-1:0] mm_cnt;

  logic              trig_start;
  logic              wait_start;
  logic              meas_start;
  logic              dist_load;
  logic [DIST_W-1:0] dist_val;

  hc_sr04_sync u_sync (
    .clk      (clk),
    .rst_n    (reset),
    .async_in (echo),
    .rise_c   (echo_rise),
    .fall_c   (echo_fall)
  );

  assign us_tick = (us_cnt == US_W'(US_LEN - 1));
  assign mm_tick = (mm_pre == MM_W'(MM_LEN - 1));

  // State register and registered trigger output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      trigger <= 1'b0;
    end else begin
      state   <= state_nxt;
      trigger <= (state_nxt == ST_TRIG);
    end
  end

  // Next-state logic and datapath strobes
  always_comb begin
    state_nxt  = state;
    trig_start = 1'b0;
    wait_start = 1'b0;
    meas_start = 1'b0;
    dist_load  = 1'b0;
    dist_val   = mm_cnt;
    unique case (state)
      ST_IDLE: begin
        state_nxt  = ST_TRIG;
        trig_start = 1'b1;
      end
      ST_TRIG: begin
        if (us_tick && per_cnt == PER_W'(TRIG_US - 1)) begin
          state_nxt  = ST_WAIT_ECHO;
          wait_start = 1'b1;
        end
      end
      ST_WAIT_ECHO: begin
        if (echo_rise) begin
          state_nxt  = ST_MEASURE;
          meas_start = 1'b1;
        end else if (tmr == TMR_W'(WAIT_LEN - 1)) begin
          state_nxt = ST_HOLD;
          dist_load = 1'b1;
          dist_val  = DIST_W'(MAX_DIST);
        end
      end
      ST_MEASURE: begin
        if (echo_fall) begin
          state_nxt = ST_HOLD;
          dist_load = 1'b1;
        end else if (tmr == TMR_W'(MEAS_LEN - 1)) begin
          state_nxt = ST_HOLD;
          dist_load = 1'b1;
          dist_val  = DIST_W'(MAX_DIST);
        end
      end
      ST_HOLD: begin
        if (us_tick && per_cnt == PER_W'(PER_US - 1)) begin
          state_nxt  = ST_TRIG;
          trig_start = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Microsecond prescaler and period counter, both realigned to each trigger start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      us_cnt  <= '0;
      per_cnt <= '0;
    end else if (trig_start) begin
      us_cnt  <= '0;
      per_cnt <= '0;
    end else begin
      us_cnt <= us_tick ? '0 : us_cnt + US_W'(1);
      if (us_tick && per_cnt != PER_W'(PER_US - 1)) begin
        per_cnt <= per_cnt + PER_W'(1);
      end
    end
  end

  // Echo timeout timer, restarted on entry to WAIT_ECHO and MEASURE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr <= '0;
    end else if (wait_start || meas_start) begin
      tmr <= '0;
    end else if (tmr != TMR_W'(TMR_LEN)) begin
      tmr <= tmr + TMR_W'(1);
    end
  end

  // Millimetre prescaler and saturating range counter; the prescaler starts at 1
  // so the detection cycle counts and the result is floor(width / MM_LEN)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mm_pre <= '0;
      mm_cnt <= '0;
    end else if (meas_start) begin
      mm_pre <= MM_W'(1);
      mm_cnt <= '0;
    end else begin
      mm_pre <= mm_tick ? '0 : mm_pre + MM_W'(1);
      if (state == ST_MEASURE && mm_tick && mm_cnt != DIST_W'(MAX_DIST)) begin
        mm_cnt <= mm_cnt + DIST_W'(1);
      end
    end
  end

  // Distance register, written only on measurement completion or timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      distance <= '0;
    end else if (dist_load) begin
      distance <= dist_val;
    end
  end

endmodule

// File: tb/tb_hc_sr04_controller.sv
// Directed bench: default-parameter instance for trigger timing and a scaled instance
// (5 MHz, 1 ms period, 300/380 us timeouts, 50 mm range) for the measurement paths.
module tb_hc_sr04_controller;

  logic        clk;
  logic        rst_d, echo_d, trig_d;
  logic [13:0] dist_d;
  logic        rst_s, echo_s, trig_s;
  logic [5:0]  dist_s;

  int n_cmp;
  int n_bad;
  int k;

  hc_sr04_controller dut_d (
    .clk      (clk),
    .reset    (rst_d),
    .echo     (echo_d),
    .trigger  (trig_d),
    .distance (dist_d)
  );

  hc_sr04_controller #(
    .CLK_HZ      (5_000_000),
    .TRIG_US     (10),
    .CYCLE_MS    (1),
    .MAX_DIST    (50),
    .TIMEOUT_US  (300),
    .ECHO_MAX_US (380)
  ) dut_s (
    .clk      (clk),
    .reset    (rst_s),
    .echo     (echo_s),
    .trigger  (trig_s),
    .distance (dist_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic goto(input int t);
    if (t > k) adv(t - k);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; k = 0;
    rst_d = 1'b1; rst_s = 1'b1; echo_d = 1'b0; echo_s = 1'b0;
    #1;
    rst_d = 1'b0; rst_s = 1'b0;
    #2;
    check("rst_trig_d", 32'(trig_d), 0);
    check("rst_dist_d", 32'(dist_d), 0);
    check("rst_trig_s", 32'(trig_s), 0);
    check("rst_dist_s", 32'(dist_s), 0);

    // Default instance: release at 10 ns, trigger 1000 clocks, 580-clock echo -> 1 mm
    #7;
    rst_d = 1'b1;
    #6;
    check("d_trig_rise", 32'(trig_d), 1);
    @(negedge clk);
    k = 0;
    goto(999);  check("d_trig_k999", 32'(trig_d), 1);
    goto(1000); check("d_trig_k1000", 32'(trig_d), 0);
    goto(1100); echo_d = 1'b1;
    goto(1680); echo_d = 1'b0;
    check("d_dist_at_fall", 32'(dist_d), 0);
    goto(1684); check("d_dist_580clk", 32'(dist_d), 1);

    // Scaled instance, cycle A: 700-clock echo (140 us) -> 24 mm, HOLD ignores echo
    goto(1700); rst_s = 1'b1;
    adv(1); k = 0;
    check("s_trig_rise", 32'(trig_s), 1);
    goto(49);   check("s_trig_k49", 32'(trig_s), 1);
    goto(50);   check("s_trig_k50", 32'(trig_s), 0);
    goto(1000); echo_s = 1'b1;
    goto(1700); echo_s = 1'b0;
    check("a_dist_at_fall", 32'(dist_s), 0);
    goto(1704); check("a_dist_24", 32'(dist_s), 24);
    goto(2000); echo_s = 1'b1;
    goto(2300); echo_s = 1'b0;
    goto(4999); check("a_dist_hold", 32'(dist_s), 24);
    check("a_trig_k4999", 32'(trig_s), 0);
    goto(5000); check("a_trig_period", 32'(trig_s), 1);
    k = 0;

    // Cycle B: no echo -> MAX_DIST when the wait timeout expires; period unchanged
    goto(1549); check("b_dist_pre_timeout", 32'(dist_s), 24);
    goto(1550); check("b_dist_timeout", 32'(dist_s), 50);
    goto(4999); check("b_trig_k4999", 32'(trig_s), 0);
    goto(5000); check("b_trig_period", 32'(trig_s), 1);
    k = 0;

    // Cycle C: echo already high entering WAIT_ECHO is ignored; later 290-clock pulse -> 10
    goto(20);  echo_s = 1'b1;
    goto(200); echo_s = 1'b0;
    goto(300); echo_s = 1'b1;
    goto(590); echo_s = 1'b0;
    check("c_dist_at_fall", 32'(dist_s), 50);
    goto(594); check("c_dist_10", 32'(dist_s), 10);
    goto(5000); check("c_trig_period", 32'(trig_s), 1);
    k = 0;

    // Cycle D: 28-clock pulse (just under 1 mm) truncates to 0
    goto(100); echo_s = 1'b1;
    goto(128); echo_s = 1'b0;
    check("d_dist_at_fall", 32'(dist_s), 10);
    goto(132); check("d_dist_trunc0", 32'(dist_s), 0);

    // Restart via reset, cycle E: echo stuck high -> MAX_DIST at 380 us, later fall ignored
    goto(200); rst_s = 1'b0;
    adv(2); rst_s = 1'b1;
    adv(1); k = 0;
    check("e_trig_restart", 32'(trig_s), 1);
    goto(100);  echo_s = 1'b1;
    goto(2000); check("e_dist_pre_timeout", 32'(dist_s), 0);
    goto(2004); check("e_dist_timeout", 32'(dist_s), 50);
    goto(2200); echo_s = 1'b0;
    goto(2210); check("e_dist_after_fall", 32'(dist_s), 50);
    goto(5000); check("e_trig_period", 32'(trig_s), 1);
    k = 0;

    // Cycle G: reset in the middle of MEASURE clears outputs at once, then restarts
    goto(100); echo_s = 1'b1;
    goto(400); rst_s = 1'b0; echo_s = 1'b0;
    #1;
    check("g_rst_trig", 32'(trig_s), 0);
    check("g_rst_dist", 32'(dist_s), 0);
    adv(3);
    check("g_rst_dist_held", 32'(dist_s), 0);
    rst_s = 1'b1;
    adv(1); k = 0;
    check("g_trig_restart", 32'(trig_s), 1);

    // Cycle F: 1700-clock pulse (58 mm) saturates at MAX_DIST
    goto(100);  echo_s = 1'b1;
    goto(1800); echo_s = 1'b0;
    check("f_dist_at_fall", 32'(dist_s), 0);
    goto(1804); check("f_dist_sat", 32'(dist_s), 50);

    check("d_dist_still_1", 32'(dist_d), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
